// File: rtl/hazard_ctrl_seq_pkg.sv
// hazard_pkg: shared types for the sequential hazard controller.
//   fwd_sel_t  : E-stage operand forwarding source (RF / W result / M result)
//   hz_state_t : hazard FSM state
// Optional feature macro used by the controller: HAZARD_PERF_CNT_EN.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    typedef enum logic [1:0] {
        RUN,
        LOAD_STALL,
        MEM_STALL
    } hz_state_t;

endpackage

// File: rtl/hazard_ctrl_seq_if.sv
// hazard_ctrl_seq_if: pipeline <-> hazard controller signal bundle.
//   master : datapath side (drives register indices/strobes, receives controls)
//   slave  : hazard controller side
// Signals: Rs1D/Rs2D/Rs1E/Rs2E/RdE/destReg_m/destReg_w, memoryRead_e,
//   RegWriteM/W, redirect, mem_stall (to controller); ForwardAE/BE,
//   stall_f/d/e/m, flush_d/e, mem_timeout (from controller).
interface hazard_ctrl_seq_if #(
    parameter int unsigned REG_AW = 5
);
    import hazard_pkg::*;

    logic [REG_AW-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, destReg_m, destReg_w;
    logic              memoryRead_e, RegWriteM, RegWriteW, redirect, mem_stall;
    fwd_sel_t          ForwardAE, ForwardBE;
    logic              stall_f, stall_d, stall_e, stall_m;
    logic              flush_d, flush_e, mem_timeout;

    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, destReg_m, destReg_w,
        output memoryRead_e, RegWriteM, RegWriteW, redirect, mem_stall,
        input  ForwardAE, ForwardBE, stall_f, stall_d, stall_e, stall_m,
        input  flush_d, flush_e, mem_timeout
    );

    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, destReg_m, destReg_w,
        input  memoryRead_e, RegWriteM, RegWriteW, redirect, mem_stall,
        output ForwardAE, ForwardBE, stall_f, stall_d, stall_e, stall_m,
        output flush_d, flush_e, mem_timeout
    );

endinterface

// File: rtl/hazard_ctrl_seq_fwd_sel.sv
// hazard_fwd_sel: combinational forward-source select for one E-stage operand.
//   rs_i          source register of the operand
//   rd_m_i/we_m_i M-stage destination and register-write strobe
//   rd_w_i/we_w_i W-stage destination and register-write strobe
//   fwd_o         selected source; M has priority over W, x0 never forwarded
module hazard_fwd_sel
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW = 5
) (
    input  logic [REG_AW-1:0] rs_i,
    input  logic [REG_AW-1:0] rd_m_i,
    input  logic [REG_AW-1:0] rd_w_i,
    input  logic              we_m_i,
    input  logic              we_w_i,
    output fwd_sel_t          fwd_o
);

    always_comb begin
        fwd_o = FWD_RF;
        if (we_m_i && (rd_m_i != '0) && (rd_m_i == rs_i)) begin
            fwd_o = FWD_MEM;
        end else if (we_w_i && (rd_w_i != '0) && (rd_w_i == rs_i)) begin
            fwd_o = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl_seq.sv
// hazard_ctrl_seq: sequential hazard controller for the 5-stage RISC-V pipe.
//   clk, rst_n : clock (rising edge), synchronous active-low reset
//   hz         : hazard_ctrl_seq_if.slave bundle (forwarding selects,
//                stall/flush controls, sticky mem_timeout)
// Optional macro HAZARD_PERF_CNT_EN adds perf_lu_cyc / perf_mem_cyc /
// perf_flush 32-bit wrapping event counters.
// Stall/flush outputs react to the current cycle's inputs (a load-use or
// redirect must act in the cycle it is seen); all outputs are 0 in reset.
module hazard_ctrl_seq
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned MEM_TMO  = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    hazard_ctrl_seq_if.slave  hz
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]       perf_lu_cyc,
    output logic [31:0]       perf_mem_cyc,
    output logic [31:0]       perf_flush
`endif
);

    fwd_sel_t  fwd_a, fwd_b;
    hz_state_t state_q, state_d, saved_q, saved_d, eff_state;
    logic [2:0]  lcnt_q, lcnt_d;
    logic [15:0] mcnt_q, mcnt_d;
    logic        pend_q, pend_d, tmo_q, tmo_d;
    logic        lu;
    logic        st_f, st_d, st_e, st_m, fl_d, fl_e;

    hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
        .rs_i(hz.Rs1E), .rd_m_i(hz.destReg_m), .rd_w_i(hz.destReg_w),
        .we_m_i(hz.RegWriteM), .we_w_i(hz.RegWriteW), .fwd_o(fwd_a)
    );

    hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
        .rs_i(hz.Rs2E), .rd_m_i(hz.destReg_m), .rd_w_i(hz.destReg_w),
        .we_m_i(hz.RegWriteM), .we_w_i(hz.RegWriteW), .fwd_o(fwd_b)
    );

    assign lu = hz.memoryRead_e && (hz.RdE != '0) &&
                ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));

    always_comb begin
        state_d = state_q;
        saved_d = saved_q;
        lcnt_d  = lcnt_q;
        pend_d  = pend_q;
        mcnt_d  = '0;
        tmo_d   = tmo_q;
        {st_f, st_d, st_e, st_m, fl_d, fl_e} = '0;
        // Leaving MEM_STALL without a pending redirect behaves exactly like
        // the state that was interrupted, with its frozen lcnt.
        eff_state = (state_q == MEM_STALL) ? saved_q : state_q;

        if (hz.mem_stall) begin
            {st_f, st_d, st_e, st_m} = '1;
            state_d = MEM_STALL;
            if (state_q != MEM_STALL) begin
                saved_d = state_q;
            end
            pend_d = pend_q | hz.redirect;
            mcnt_d = (mcnt_q < 16'(MEM_TMO)) ? mcnt_q + 16'd1 : mcnt_q;
            if (mcnt_d == 16'(MEM_TMO)) begin
                tmo_d = 1'b1;
            end
        end else if (pend_q) begin
            // Replay the held redirect; any interrupted load stall is dropped.
            fl_d    = 1'b1;
            fl_e    = 1'b1;
            pend_d  = 1'b0;
            lcnt_d  = '0;
            state_d = RUN;
        end else begin
            case (eff_state)
                LOAD_STALL: begin
                    if (hz.redirect) begin
                        fl_d    = 1'b1;
                        fl_e    = 1'b1;
                        lcnt_d  = '0;
                        state_d = RUN;
                    end else begin
                        st_f   = 1'b1;
                        st_d   = 1'b1;
                        fl_e   = 1'b1;
                        lcnt_d = lcnt_q - 3'd1;
                        state_d = (lcnt_q == 3'd1) ? RUN : LOAD_STALL;
                    end
                end
                default: begin
                    state_d = RUN;
                    if (hz.redirect) begin
                        fl_d = 1'b1;
                        fl_e = 1'b1;
                    end else if (lu) begin
                        st_f = 1'b1;
                        st_d = 1'b1;
                        fl_e = 1'b1;
                        if (LOAD_LAT > 1) begin
                            lcnt_d  = 3'(LOAD_LAT - 1);
                            state_d = LOAD_STALL;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RUN;
            saved_q <= RUN;
            lcnt_q  <= '0;
            mcnt_q  <= '0;
            pend_q  <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            saved_q <= saved_d;
            lcnt_q  <= lcnt_d;
            mcnt_q  <= mcnt_d;
            pend_q  <= pend_d;
            tmo_q   <= tmo_d;
        end
    end

    assign hz.ForwardAE   = rst_n ? fwd_a : FWD_RF;
    assign hz.ForwardBE   = rst_n ? fwd_b : FWD_RF;
    assign hz.stall_f     = rst_n & st_f;
    assign hz.stall_d     = rst_n & st_d;
    assign hz.stall_e     = rst_n & st_e;
    assign hz.stall_m     = rst_n & st_m;
    assign hz.flush_d     = rst_n & fl_d;
    assign hz.flush_e     = rst_n & fl_e;
    assign hz.mem_timeout = rst_n & tmo_q;

`ifdef HAZARD_PERF_CNT_EN
    // Load-use cycles are bubble-insert cycles (stall_d without stall_e);
    // flush events are redirect flushes, which always raise flush_d.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_lu_cyc  <= '0;
            perf_mem_cyc <= '0;
            perf_flush   <= '0;
        end else begin
            if (st_d && !st_e) perf_lu_cyc <= perf_lu_cyc + 32'd1;
            if (hz.mem_stall)  perf_mem_cyc <= perf_mem_cyc + 32'd1;
            if (fl_d)          perf_flush <= perf_flush + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl_seq.sv
// Directed self-checking bench for hazard_ctrl_seq (LOAD_LAT = 3, MEM_TMO = 10).
module tb_hazard_ctrl_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int unsigned total = 0;
    int unsigned bad = 0;

    always #5 clk = ~clk;

    hazard_ctrl_seq_if #(.REG_AW(5)) hz ();

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_lu_cyc, perf_mem_cyc, perf_flush;
`endif

    hazard_ctrl_seq #(.REG_AW(5), .LOAD_LAT(3), .MEM_TMO(10)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .hz(hz.slave)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .perf_lu_cyc(perf_lu_cyc),
        .perf_mem_cyc(perf_mem_cyc),
        .perf_flush(perf_flush)
`endif
    );

    // {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e}
    logic [5:0] ctl;
    assign ctl = {hz.stall_f, hz.stall_d, hz.stall_e, hz.stall_m, hz.flush_d, hz.flush_e};

    localparam logic [5:0] NONE  = 6'b000000;
    localparam logic [5:0] LUSE  = 6'b110001;
    localparam logic [5:0] REDIR = 6'b000011;
    localparam logic [5:0] MSTL  = 6'b111100;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_inputs();
        hz.Rs1D = '0; hz.Rs2D = '0; hz.Rs1E = '0; hz.Rs2E = '0; hz.RdE = '0;
        hz.destReg_m = '0; hz.destReg_w = '0;
        hz.memoryRead_e = 1'b0; hz.RegWriteM = 1'b0; hz.RegWriteW = 1'b0;
        hz.redirect = 1'b0; hz.mem_stall = 1'b0;
    endtask

    initial begin
        clr_inputs();
        // Reset: forwarding conditions present but outputs must stay 0.
        hz.RegWriteM = 1'b1; hz.destReg_m = 5'd5; hz.Rs1E = 5'd5;
        nxt(); nxt();
        chk("rst_ctl", 32'(ctl), 32'(NONE));
        chk("rst_fwdA", 32'(hz.ForwardAE), 32'd0);
        chk("rst_tmo", 32'(hz.mem_timeout), 32'd0);
`ifdef HAZARD_PERF_CNT_EN
        chk("rst_perf", perf_lu_cyc | perf_mem_cyc | perf_flush, 32'd0);
`endif
        rst_n = 1'b1;
        clr_inputs();
        nxt();

        // 1. Forwarding
        hz.RegWriteM = 1'b1; hz.destReg_m = 5'd5; hz.RegWriteW = 1'b1; hz.destReg_w = 5'd5;
        hz.Rs1E = 5'd5; hz.Rs2E = 5'd5;
        #1;
        chk("fwdA_m_over_w", 32'(hz.ForwardAE), 32'd2);
        chk("fwdB_m_over_w", 32'(hz.ForwardBE), 32'd2);
        chk("fwd_ctl", 32'(ctl), 32'(NONE));
        hz.destReg_m = 5'd0;
        #1;
        chk("fwdA_m_x0", 32'(hz.ForwardAE), 32'd1);
        hz.RegWriteW = 1'b0;
        #1;
        chk("fwdA_no_we", 32'(hz.ForwardAE), 32'd0);
        hz.Rs1E = 5'd3; hz.destReg_m = 5'd3; hz.RegWriteM = 1'b0;
        hz.destReg_w = 5'd3; hz.RegWriteW = 1'b1; hz.Rs2E = 5'd9;
        #1;
        chk("fwdA_w_only", 32'(hz.ForwardAE), 32'd1);
        chk("fwdB_nomatch", 32'(hz.ForwardBE), 32'd0);
        hz.Rs2E = 5'd0; hz.destReg_m = 5'd0; hz.destReg_w = 5'd0; hz.RegWriteM = 1'b1;
        #1;
        chk("fwdB_x0", 32'(hz.ForwardBE), 32'd0);
        clr_inputs();
        nxt();

        // 2. Load-use, LOAD_LAT = 3
        hz.memoryRead_e = 1'b1; hz.RdE = 5'd7; hz.Rs2D = 5'd7;
        #1;
        chk("lu_c1", 32'(ctl), 32'(LUSE));
        nxt();
        clr_inputs();
        #1;
        chk("lu_c2", 32'(ctl), 32'(LUSE));
        nxt();
        chk("lu_c3", 32'(ctl), 32'(LUSE));
        nxt();
        chk("lu_done", 32'(ctl), 32'(NONE));
        hz.memoryRead_e = 1'b1; hz.RdE = 5'd0; hz.Rs2D = 5'd0; hz.Rs1D = 5'd0;
        #1;
        chk("lu_x0", 32'(ctl), 32'(NONE));
        clr_inputs();
        nxt();

        // 3. Redirect in RUN, then redirect during load stall
        hz.redirect = 1'b1;
        #1;
        chk("redir_run", 32'(ctl), 32'(REDIR));
        nxt();
        hz.redirect = 1'b0;
        hz.memoryRead_e = 1'b1; hz.RdE = 5'd4; hz.Rs1D = 5'd4;
        #1;
        chk("lu_redir_c1", 32'(ctl), 32'(LUSE));
        nxt();
        clr_inputs();
        hz.redirect = 1'b1;
        #1;
        chk("lu_redir_c2", 32'(ctl), 32'(REDIR));
        nxt();
        hz.redirect = 1'b0;
        #1;
        chk("lu_redir_c3", 32'(ctl), 32'(NONE));
        nxt();

        // 4. Memory stall with redirect held and replayed
        hz.mem_stall = 1'b1;
        #1;
        chk("ms_c1", 32'(ctl), 32'(MSTL));
        nxt();
        hz.redirect = 1'b1;
        #1;
        chk("ms_c2", 32'(ctl), 32'(MSTL));
        nxt();
        hz.redirect = 1'b0;
        #1;
        chk("ms_c3", 32'(ctl), 32'(MSTL));
        nxt();
        chk("ms_c4", 32'(ctl), 32'(MSTL));
        nxt();
        hz.mem_stall = 1'b0;
        #1;
        chk("ms_replay", 32'(ctl), 32'(REDIR));
        nxt();
        chk("ms_after", 32'(ctl), 32'(NONE));

        // 4b. Memory stall interrupting a load stall resumes it
        hz.memoryRead_e = 1'b1; hz.RdE = 5'd6; hz.Rs2D = 5'd6;
        #1;
        chk("lums_c1", 32'(ctl), 32'(LUSE));
        nxt();
        clr_inputs();
        hz.mem_stall = 1'b1;
        #1;
        chk("lums_ms", 32'(ctl), 32'(MSTL));
        nxt();
        hz.mem_stall = 1'b0;
        #1;
        chk("lums_c2", 32'(ctl), 32'(LUSE));
        nxt();
        chk("lums_c3", 32'(ctl), 32'(LUSE));
        nxt();
        chk("lums_done", 32'(ctl), 32'(NONE));

        // 5. Timeout after 10 stalled cycles, sticky
        hz.mem_stall = 1'b1;
        for (int i = 0; i < 9; i++) nxt();
        chk("tmo_9", 32'(hz.mem_timeout), 32'd0);
        nxt();
        chk("tmo_10", 32'(hz.mem_timeout), 32'd1);
        nxt(); nxt();
        hz.mem_stall = 1'b0;
        #1;
        chk("tmo_rel_ctl", 32'(ctl), 32'(NONE));
        nxt();
        chk("tmo_sticky", 32'(hz.mem_timeout), 32'd1);

        // 6. Reset in the middle of a load stall
        hz.memoryRead_e = 1'b1; hz.RdE = 5'd8; hz.Rs1D = 5'd8;
        #1;
        chk("rlu_c1", 32'(ctl), 32'(LUSE));
        nxt();
        clr_inputs();
        #1;
        chk("rlu_c2", 32'(ctl), 32'(LUSE));
        rst_n = 1'b0;
        hz.RegWriteM = 1'b1; hz.destReg_m = 5'd5; hz.Rs1E = 5'd5;
        #1;
        chk("rlu_rst_ctl", 32'(ctl), 32'(NONE));
        chk("rlu_rst_fwd", 32'(hz.ForwardAE), 32'd0);
        nxt();
        rst_n = 1'b1;
        clr_inputs();
        #1;
        chk("rlu_run_ctl", 32'(ctl), 32'(NONE));
        chk("rlu_tmo_clr", 32'(hz.mem_timeout), 32'd0);
`ifdef HAZARD_PERF_CNT_EN
        chk("rlu_perf", perf_lu_cyc | perf_mem_cyc | perf_flush, 32'd0);
`endif
        hz.memoryRead_e = 1'b1; hz.RdE = 5'd8; hz.Rs1D = 5'd8;
        #1;
        chk("rlu_fresh", 32'(ctl), 32'(LUSE));
        nxt();
        clr_inputs();
        #1;
        chk("rlu_fresh_c2", 32'(ctl), 32'(LUSE));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
